alu_arbiter: RTL

Round-robin arbiter and sequencer that shares the single-cycle combinational `alu` between `NUM_REQ` independent requesters. Each requester issues an operation (operands plus 3-bit ALU control) over a valid/ready handshake. The block registers the winning request, drives the shared ALU for one execute cycle, and captures `result` and `zero`. It returns them tagged with the requester index on one shared response channel that supports back-pressure.

---
 rtl/alu_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NUM_REQ valid/ready requesters
// Ports: req_valid/req_ready/req_a/req_b/req_op per-requester operations with one-hot grant;
// rsp_* tagged response with back-pressure; alu_* drive and return of the external ALU;
// ops_done counts completed response handshakes (wraps at 16 bits).
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*3-1:0]   req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
  output logic                   rsp_zero,
  output logic                   rsp_err,
  output logic [31:0]            alu_src_a,
  output logic [31:0]            alu_src_b,
  output logic [2:0]             alu_ctrl,
  input  logic [31:0]            alu_result,
  input  logic                   alu_zero,
  output logic [15:0]            ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, win, cur_id;
  logic found, ill;
  // scanning from the farthest offset down lets the nearest valid requester at or after rr_ptr win
  always_comb begin
    win = rr_ptr;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        win = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  assign ill = alu_ctrl inside {3'b011, 3'b100, 3'b101};
  always_comb begin
    state_nx = state;
    req_ready = (state == IDLE && found) ? NUM_REQ'(1) << win : '0;
    rsp_valid = state == RESP;
    if (state == IDLE && found) state_nx = EXEC;
    else if (state == EXEC) state_nx = RESP;
    else if (state == RESP && rsp_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      cur_id <= '0;
      alu_src_a <= '0;
      alu_src_b <= '0;
      alu_ctrl <= '0;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
      rsp_err <= 1'b0;
      ops_done <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        alu_src_a <= req_a[32*win +: 32];
        alu_src_b <= req_b[32*win +: 32];
        alu_ctrl <= req_op[3*win +: 3];
        cur_id <= win;
        rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
      if (state == EXEC) begin
        rsp_id <= cur_id;
        rsp_result <= ill ? 32'd0 : alu_result;
        rsp_zero <= ill ? 1'b0 : alu_zero;
        rsp_err <= ill;
      end
      if (state == RESP && rsp_ready) ops_done <= ops_done + 16'd1;
    end
  end
endmodule
